// File: rtl/tt_chandrakanth_pkg.sv
// Shared definitions for the byte-serial logic unit tile: opcodes, FSM state
// encoding and uio pin indices.
package tt_chandrakanth_pkg;

  localparam logic [2:0] OP_NAND  = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  localparam int PIN_OP_LSB    = 0;
  localparam int PIN_IN_VALID  = 3;
  localparam int PIN_OUT_READY = 4;
  localparam int PIN_IN_READY  = 5;
  localparam int PIN_OUT_VALID = 6;
  localparam int PIN_PARITY    = 7;

endpackage

// File: rtl/chandrakanth_logic_op.sv
// Combinational WIDTH-bit bitwise gate unit: Y = op(A, B).
module chandrakanth_logic_op
  import tt_chandrakanth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Select one of the eight gate functions; B is ignored for NOT A / PASS A.
  always_comb begin
    o_y = '0;
    unique case (i_op)
      OP_NAND:  o_y = ~(i_a & i_b);
      OP_AND:   o_y = i_a & i_b;
      OP_OR:    o_y = i_a | i_b;
      OP_NOR:   o_y = ~(i_a | i_b);
      OP_XOR:   o_y = i_a ^ i_b;
      OP_XNOR:  o_y = ~(i_a ^ i_b);
      OP_NOTA:  o_y = ~i_a;
      OP_PASSA: o_y = i_a;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/tt_um_chandrakanth_logic_unit.sv
// Byte-serial bitwise logic unit tile. Loads A then B little-endian over
// ui_in, computes one gate op in EXEC and streams the result out under a
// valid/ready handshake. Optional result parity on uio_out[7] is enabled by
// defining LOGIC_UNIT_PARITY_EN.
module tt_um_chandrakanth_logic_unit
  import tt_chandrakanth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   w_y;

  logic w_in_valid;
  logic w_out_ready;
  logic w_in_ready;
  logic w_out_valid;
  logic w_parity;
  logic w_accept;
  logic w_retire;
  logic w_last;
  logic w_unused;

  assign w_in_valid  = uio_in[PIN_IN_VALID];
  assign w_out_ready = uio_in[PIN_OUT_READY];
  assign w_unused    = ^{ena, uio_in[7:5]};

  assign w_accept = w_in_valid & w_in_ready;
  assign w_retire = w_out_ready & w_out_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  chandrakanth_logic_op #(.WIDTH(WIDTH)) u_op (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD_A;
    else        r_state <= w_next_state;
  end

  // Next-state logic: advance on the last accepted/retired byte.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_LOAD_A: if (w_accept && w_last) w_next_state = ST_LOAD_B;
      ST_LOAD_B: if (w_accept && w_last) w_next_state = ST_EXEC;
      ST_EXEC:   w_next_state = ST_SEND;
      ST_SEND:   if (w_retire && w_last) w_next_state = ST_LOAD_A;
      default:   w_next_state = ST_LOAD_A;
    endcase
  end

  // State-decoded outputs; the result byte comes only from registers.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    uo_out      = 8'h00;
    unique case (r_state)
      ST_LOAD_A, ST_LOAD_B: w_in_ready = 1'b1;
      ST_SEND: begin
        w_out_valid = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
          if (r_cnt == CNT_W'(i)) uo_out = r_res[i*8 +: 8];
        end
      end
      default: ;
    endcase
  end

  // Byte counter shared by the load and send phases; wraps on the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept || w_retire) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Operand capture, opcode latch on A byte 0, and result register in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_op  <= '0;
    end else begin
      if (w_accept && r_state == ST_LOAD_A) begin
        if (r_cnt == '0) r_op <= uio_in[PIN_OP_LSB +: 3];
        for (int i = 0; i < NBYTES; i++) begin
          if (r_cnt == CNT_W'(i)) r_a[i*8 +: 8] <= ui_in;
        end
      end
      if (w_accept && r_state == ST_LOAD_B) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (r_cnt == CNT_W'(i)) r_b[i*8 +: 8] <= ui_in;
        end
      end
      if (r_state == ST_EXEC) r_res <= w_y;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  assign w_parity = w_out_valid & (^r_res);
  assign uio_oe   = 8'hE0;
`else
  assign w_parity = 1'b0;
  assign uio_oe   = 8'h60;
`endif

  assign uio_out = {w_parity, w_out_valid, w_in_ready, 5'b00000};

endmodule

// File: tb/tb_tt_um_chandrakanth_logic_unit.sv
// Directed-vector bench for the byte-serial logic unit (WIDTH=16).
module tb_tt_um_chandrakanth_logic_unit;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [2:0] op_r;
  logic       in_valid;
  logic       out_ready;

  int n_tests;
  int n_fail;

`ifdef LOGIC_UNIT_PARITY_EN
  localparam logic       PAR_ON = 1'b1;
  localparam logic [7:0] OE_EXP = 8'hE0;
`else
  localparam logic       PAR_ON = 1'b0;
  localparam logic [7:0] OE_EXP = 8'h60;
`endif

  assign uio_in = {3'b000, out_ready, in_valid, op_r};

  tt_um_chandrakanth_logic_unit #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load A then B; the opcode pins are scrambled after A byte 0 to prove the latch.
  task automatic load(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [7:0] bytes [4];
    bytes[0] = a[7:0];
    bytes[1] = a[15:8];
    bytes[2] = b[7:0];
    bytes[3] = b[15:8];
    op_r = op;
    for (int i = 0; i < 4; i++) begin
      ui_in    = bytes[i];
      in_valid = 1'b1;
      tick();
      if (i == 0) op_r = ~op;
    end
    in_valid = 1'b0;
  endtask

  // Full transaction with out_ready high through SEND.
  task automatic run_txn(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input logic par);
    load(op, a, b);
    chk({tag, "_exec_ov"}, uio_out[6], 1'b0);
    chk({tag, "_exec_ir"}, uio_out[5], 1'b0);
    tick();
    out_ready = 1'b1;
    chk({tag, "_b0"}, uo_out, exp[7:0]);
    chk({tag, "_ov0"}, uio_out[6], 1'b1);
    chk({tag, "_par0"}, uio_out[7], par & PAR_ON);
    tick();
    chk({tag, "_b1"}, uo_out, exp[15:8]);
    chk({tag, "_par1"}, uio_out[7], par & PAR_ON);
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_ir"}, uio_out[5], 1'b1);
    chk({tag, "_done_ov"}, uio_out[6], 1'b0);
    chk({tag, "_done_uo"}, uo_out, 8'h00);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ena       = 1'b1;
    ui_in     = 8'h00;
    op_r      = 3'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();

    chk("rst_uo", uo_out, 8'h00);
    chk("rst_ov", uio_out[6], 1'b0);
    chk("rst_ir", uio_out[5], 1'b1);
    chk("rst_par", uio_out[7], 1'b0);
    chk("rst_lo", uio_out[4:0], 5'd0);
    chk("rst_oe", uio_oe, OE_EXP);
    rst_n = 1'b1;
    tick();

    // NAND: ~(0x00FF & 0x0F0F) = 0xFFF0, even parity.
    run_txn("nand", 3'd0, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0);

    // XOR with backpressure: 0x1234 ^ 0xFFFF = 0xEDCB, odd parity.
    load(3'd4, 16'h1234, 16'hFFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("xor_hold_uo", uo_out, 8'hCB);
      chk("xor_hold_ov", uio_out[6], 1'b1);
      tick();
    end
    chk("xor_b0", uo_out, 8'hCB);
    chk("xor_par", uio_out[7], PAR_ON);
    out_ready = 1'b1;
    tick();
    chk("xor_b1", uo_out, 8'hED);
    tick();
    out_ready = 1'b0;
    chk("xor_done_ir", uio_out[5], 1'b1);

    // Stray input during EXEC/SEND must be dropped: OR 0x1200|0x0034 = 0x1234.
    load(3'd2, 16'h1200, 16'h0034);
    ui_in    = 8'hAA;
    in_valid = 1'b1;
    tick();
    chk("ign_b0", uo_out, 8'h34);
    tick();
    chk("ign_hold", uo_out, 8'h34);
    out_ready = 1'b1;
    tick();
    chk("ign_b1", uo_out, 8'h12);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("ign_done_ir", uio_out[5], 1'b1);
    // PASS A 0x5A3C; a captured 0xAA would corrupt the low byte.
    run_txn("ign_next", 3'd7, 16'h5A3C, 16'h0000, 16'h5A3C, 1'b0);

    // Remaining ops.
    run_txn("nor", 3'd3, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0);
    run_txn("xnor", 3'd5, 16'hFF00, 16'h0F0F, 16'h0FF0, 1'b0);
    run_txn("nota", 3'd6, 16'h1234, 16'h5555, 16'hEDCB, 1'b1);

    // Reset mid-load after A and one B byte.
    op_r = 3'd0;
    ui_in = 8'h11; in_valid = 1'b1; tick();
    ui_in = 8'h22; tick();
    ui_in = 8'h33; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("mid_rst_ir", uio_out[5], 1'b1);
    chk("mid_rst_ov", uio_out[6], 1'b0);
    rst_n = 1'b1;
    tick();
    run_txn("and", 3'd1, 16'hF0F0, 16'hFFFF, 16'hF0F0, 1'b0);

    // Parity probe: PASS A 0x0001 has odd parity.
    run_txn("pass", 3'd7, 16'h0001, 16'h0000, 16'h0001, 1'b1);
    chk("end_oe", uio_oe, OE_EXP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_chandrakanth_logic_unit.md
# tt_um_chandrakanth_logic_unit

Parametrised, byte-serial successor to the single NAND gate tile. It loads two WIDTH-bit operands over the 8-bit input bus and applies one of eight bitwise gate operations, selected per transaction. The result is returned byte by byte under a valid/ready handshake. It sits as a standalone user tile behind the standard pin wrapper; opcode 0 (NAND) preserves the original function.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 8, range 8..64; NBYTES = WIDTH/8
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  operand byte in
- uio_in  input  8  [2:0] opcode, [3] in_valid, [4] out_ready, [7:5] unused
- uo_out  output  8  result byte out; 0 when out_valid=0
- uio_out  output  8  [5] in_ready, [6] out_valid, [7] parity, [4:0]=0
- uio_oe  output  8  constant 8'hE0 (8'h60 without parity)

## Operation
- States: LOAD_A, LOAD_B, EXEC, SEND. Byte counter 0..NBYTES-1.
- in_ready = 1 in LOAD_A/LOAD_B, else 0. A byte is accepted on a rising edge with in_valid=1 and in_ready=1.
- Bytes arrive little-endian (first byte = bits [7:0]).
- Opcode is latched at acceptance of A byte 0. Later changes to uio_in[2:0] are ignored until the next transaction.
- State transitions:
  - LOAD_A → LOAD_B after A byte NBYTES-1.
  - LOAD_B → EXEC after B byte NBYTES-1.
  - EXEC → SEND unconditionally after 1 cycle; result register loaded.
- Opcodes: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A. B is always loaded, even for opcodes 6 and 7.
- SEND behaviour:
  - out_valid=1 and uo_out = result byte[counter].
  - The byte retires on an edge with out_ready=1.
  - After the last byte retires: state → LOAD_A, counter → 0.
- in_valid during EXEC/SEND is ignored; those bytes are dropped, not queued.
- With out_ready held high, one byte retires per cycle.
- Reset values (asynchronous): state LOAD_A, counter 0, A/B/result/opcode 0, uo_out 0, out_valid 0, parity 0, in_ready 1.
- Reset mid-transaction abandons all partial data. The next transaction starts from A byte 0.

## Timing
- Load: 2·NBYTES accepting edges minimum.
- The edge that accepts the last B byte enters EXEC. The next edge registers the result and enters SEND.
- Byte 0 is valid 2 edges after the last B byte is presented with in_valid.
- Minimum transaction: 2·NBYTES + 1 + NBYTES cycles.
- Back-to-back: A byte 0 of the next transaction is accepted at the earliest on the edge after the last result byte retires.
- uo_out, out_valid and parity are registered or state-decoded only. There are no combinational paths from ui_in/uio_in to any output.

## Configuration
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined: uio_out[7] = XOR-reduction of the full WIDTH-bit result. It is valid while out_valid=1 and 0 otherwise. uio_oe = 8'hE0.
- Undefined: uio_out[7] = 0 and uio_oe = 8'h60. No parity logic is synthesised.

## Structure
- Shared package tt_chandrakanth_pkg:
  - opcode localparams (OP_NAND..OP_PASSA, 3 bits)
  - state encoding (2 bits)
  - pin-index localparams for the uio bits
- Sub-module chandrakanth_logic_op: combinational WIDTH-bit op unit (opcode, A, B → Y), instantiated once in EXEC.
- The top module holds the FSM, byte counter, operand/result registers and the pin mapping.

## Test plan
All cases use WIDTH=16.
- Reset: hold rst_n=0 → uo_out=0x00, out_valid=0, in_ready=1, uio_oe=0xE0 (parity on).
- NAND: op=0, A bytes FF,00 (A=0x00FF), B bytes 0F,0F (B=0x0F0F), out_ready=1 → uo_out F0 then FF on consecutive cycles, parity=0; then in_ready=1.
- XOR with backpressure: op=4, A=0x1234, B=0xFFFF, out_ready=0 for 3 cycles in SEND → uo_out holds 0xCB with out_valid=1; after release, 0xCB then 0xED.
- Ignored input: pulse in_valid with ui_in=0xAA during EXEC and SEND → result unchanged; next transaction's A byte 0 is the first byte sent after SEND ends.
- Reset mid-load: after A loaded and 1 B byte, pulse rst_n low → state LOAD_A; a fresh op=1 with A=0xF0F0, B=0xFFFF yields bytes F0,F0.
- Parity/config: op=7, A=0x0001, B=0x0000 → bytes 01,00 with parity=1. Without LOGIC_UNIT_PARITY_EN → uio_out[7]=0 and uio_oe=0x60.
